// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with IDLE/BUSY/DONE handshake; define ALU_SEQ_MUL_EN to build the shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SH = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] BUSY = 2'd1;
`endif
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             res_err;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH-1:0]    shamt;
    logic signed [WIDTH-1:0] sra_res;

    assign sum      = a + b;
    assign diff     = a - b;
    assign shamt    = b[SH-1:0];
    assign sra_res  = $signed(a) >>> shamt;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle ops; func 11 lands in default and only reaches here when MUL is not built.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (func)
            4'd0: begin
                res     = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                res     = diff;
                res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = ~(a | b);
            4'd5:    res = WIDTH'(a < b);
            4'd6:    res = WIDTH'($signed(a) < $signed(b));
            4'd7:    res = a ^ b;
            4'd8:    res = a << shamt;
            4'd9:    res = a >> shamt;
            4'd10:   res = sra_res;
            default: res_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SH-1:0] LAST_STEP = SH'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SH-1:0]    step;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out       <= '0;
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            err_flag  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            step      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                        if (func == 4'd11) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            step   <= '0;
                            state  <= BUSY;
                        end else begin
`else
                        begin
`endif
                            out       <= res;
                            zero_flag <= (res == '0);
                            ovf_flag  <= res_ovf;
                            err_flag  <= res_err;
                            state     <= DONE;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + 1'b1;
                    // The last step writes the result directly so DONE follows the final add.
                    if (step == LAST_STEP) begin
                        out       <= acc_next;
                        zero_flag <= (acc_next == '0);
                        ovf_flag  <= 1'b0;
                        err_flag  <= 1'b0;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
